// File: rtl/ram_access_arbiter.sv
// Sequencer/arbiter for a single-port 32x4 RAM: zero-sweep after reset, then one access per cycle
// shared between requesters A and B. Define ARB_ROUND_ROBIN_EN for alternating arbitration.
module ram_access_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {S_WAIT, S_CLEAR, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              run, a_win, b_win;

  assign run  = (state == S_RUN);
  assign busy = ~run;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = B held the last grant, so A wins the next tie
  logic last_b;

  always_comb begin
    a_win = a_req & (~b_req | last_b);
    b_win = b_req & ~a_win;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)   last_b <= 1'b1;
    else if (a_gnt) last_b <= 1'b0;
    else if (b_gnt) last_b <= 1'b1;
  end
`else
  always_comb begin
    a_win = a_req;
    b_win = b_req & ~a_req;
  end
`endif

  assign a_gnt = run & a_win;
  assign b_gnt = run & b_win;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ram_wren    = 1'b0;
    ram_address = hold_addr;
    ram_data    = hold_data;
    case (state)
      S_WAIT: state_nxt = S_CLEAR;
      S_CLEAR: begin
        ram_wren    = 1'b1;
        ram_address = cnt;
        ram_data    = '0;
        cnt_nxt     = cnt + 1'b1;
        if (cnt == '1) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (a_gnt) begin
          ram_wren    = a_we;
          ram_address = a_addr;
          ram_data    = a_wdata;
        end else if (b_gnt) begin
          ram_wren    = b_we;
          ram_address = b_addr;
          ram_data    = b_wdata;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Idle cycles keep the last address/data on the RAM bus
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_WAIT;
      cnt       <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_addr <= ram_address;
      hold_data <= ram_data;
      a_rvalid  <= a_gnt & ~a_we;
      b_rvalid  <= b_gnt & ~b_we;
    end
  end

  assign a_rdata = ram_q;
  assign b_rdata = ram_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench for ram_access_arbiter with a behavioural RAM and a cycle-count reference model.
module tb_ram_access_arbiter;
  localparam int AW = 5, DW = 4, DEPTH = 32;

  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren, busy;
  logic [DW-1:0] a_rdata, b_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  always #5 CLOCK_50 = ~CLOCK_50;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy));

  // ram32x4: sync write, registered address, preloaded with nonzero garbage
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_areg;
  logic          seeded = 1'b0;
  always @(posedge CLOCK_50) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'($urandom_range(1, 15));
      seeded <= 1'b1;
    end else if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_areg <= ram_address;
  end
  assign ram_q = ram_mem[ram_areg];

  // reference model: cyc counts cycles since reset release (0 = wait, 1..32 = clear)
  int total = 0, bad = 0;
  int cyc = 0, mode = 2, n_agnt = 0;
  bit rel = 0, m_last_b = 1, eg_a = 0, eg_b = 0, e_arv = 0, e_brv = 0, e_wren = 0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_ha = '0, e_addr = '0;
  logic [DW-1:0] m_hd = '0, e_data = '0, e_ad = '0, e_bd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_phase();
    bit run;
    @(negedge CLOCK_50);
    run  = rel && (cyc >= DEPTH + 1);
    eg_a = 0; eg_b = 0;
    if (run) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (a_req && b_req) begin eg_a = m_last_b; eg_b = !m_last_b; end
      else begin eg_a = a_req; eg_b = b_req; end
`else
      eg_a = a_req; eg_b = !a_req && b_req;
`endif
    end
    e_wren = 0; e_addr = m_ha; e_data = m_hd;
    if (rel && cyc >= 1 && cyc <= DEPTH) begin
      e_wren = 1; e_addr = AW'(cyc - 1); e_data = '0;
    end else if (eg_a) begin
      e_wren = a_we; e_addr = a_addr; e_data = a_wdata;
    end else if (eg_b) begin
      e_wren = b_we; e_addr = b_addr; e_data = b_wdata;
    end
    chk("busy", 32'(busy), 32'(!run));
    chk("a_gnt", 32'(a_gnt), 32'(eg_a));
    chk("b_gnt", 32'(b_gnt), 32'(eg_b));
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_data", 32'(ram_data), 32'(e_data));
    chk("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    if (e_arv) chk("a_rdata", 32'(a_rdata), 32'(e_ad));
    if (e_brv) chk("b_rdata", 32'(b_rdata), 32'(e_bd));
  endtask

  task automatic upd_req();
    if (mode == 0) begin
      if (eg_a || !a_req) begin
        a_req = ($urandom % 3) != 0; a_we = 1'($urandom);
        a_addr = AW'($urandom % 8); a_wdata = DW'($urandom);
      end
      if (eg_b || !b_req) begin
        b_req = ($urandom % 3) != 0; b_we = 1'($urandom);
        b_addr = AW'($urandom % 8); b_wdata = DW'($urandom);
      end
    end else if (mode == 1) begin
      if (eg_a) begin a_req = 1; a_we = 0; a_addr = AW'($urandom); end
      if (eg_b) begin b_req = 1; b_we = 0; b_addr = AW'($urandom); end
    end else begin
      if (eg_a) a_req = 0;
      if (eg_b) b_req = 0;
    end
  endtask

  task automatic adv_phase();
    @(posedge CLOCK_50);
    if (rel) begin
      if (e_wren) m_mem[e_addr] = e_data;
      m_ha = e_addr; m_hd = e_data;
      e_arv = eg_a && !a_we; e_ad = m_mem[a_addr];
      e_brv = eg_b && !b_we; e_bd = m_mem[b_addr];
      if (eg_a) begin m_last_b = 0; n_agnt++; end
      else if (eg_b) m_last_b = 1;
      cyc++;
    end
    #1;
    upd_req();
  endtask

  task automatic step();
    check_phase();
    adv_phase();
  endtask

  task automatic pulse_reset(input int hold);
    reset_n = 0;
    #1;
    rel = 0; cyc = 0; m_ha = '0; m_hd = '0; m_last_b = 1;
    e_arv = 0; e_brv = 0; eg_a = 0; eg_b = 0;
    chk("rst_a_gnt", 32'(a_gnt), 32'(0));
    chk("rst_b_gnt", 32'(b_gnt), 32'(0));
    chk("rst_a_rvalid", 32'(a_rvalid), 32'(0));
    chk("rst_b_rvalid", 32'(b_rvalid), 32'(0));
    chk("rst_ram_wren", 32'(ram_wren), 32'(0));
    chk("rst_ram_address", 32'(ram_address), 32'(0));
    chk("rst_ram_data", 32'(ram_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    repeat (hold) step();
    reset_n = 1;
    rel = 1;
  endtask

  initial begin
    #2;
    pulse_reset(3);
    repeat (DEPTH + 1) step();
    // sweep result: B reads back every location
    for (int i = 0; i < DEPTH; i++) begin
      b_req = 1; b_we = 0; b_addr = AW'(i);
      step();
    end
    step();
    // write then read back through A
    a_req = 1; a_we = 1; a_addr = 5'd1; a_wdata = 4'hC; step();
    a_req = 1; a_we = 0; a_addr = 5'd1; step();
    step();
    // A write collides with B read of the same address
    a_req = 1; a_we = 1; a_addr = 5'd3; a_wdata = 4'h8;
    b_req = 1; b_we = 0; b_addr = 5'd3;
    repeat (3) step();
    // both held for 8 cycles
    mode = 1; n_agnt = 0;
    a_req = 1; a_we = 0; b_req = 1; b_we = 0;
    repeat (8) step();
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb_a_count", 32'(n_agnt), 32'(4));
`else
    chk("arb_a_count", 32'(n_agnt), 32'(8));
`endif
    mode = 2; a_req = 0; b_req = 0;
    step();
    mode = 0;
    repeat (400) step();
    // reset in the middle of the clear sweep
    mode = 2; a_req = 0; b_req = 0;
    pulse_reset(2);
    while (cyc != 11) step();
    check_phase();
    pulse_reset(2);
    repeat (DEPTH + 2) step();
    // reset lands between a read grant and its rvalid
    a_req = 1; a_we = 0; a_addr = 5'd5;
    check_phase();
    pulse_reset(2);
    repeat (DEPTH + 4) step();
    mode = 0;
    repeat (200) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
